// File: rtl/key_event_tx.sv
// key_event_tx
//
// Scans a bank of raw key flags one key per clock after each sample strobe,
// debounces every key with its own saturating counter, and queues a byte
// per committed press/release into a small FIFO that feeds a UART
// transmitter through a valid/ready handshake.
//
// Parameters
//   NUM_KEYS        number of key inputs (1..128)
//   STABLE_SAMPLES  consecutive differing samples needed to commit a change
//   FIFO_DEPTH      event FIFO depth in bytes (power of two, >= 2)
//
// Ports
//   clk            rising-edge clock for all logic
//   rst            synchronous active-high reset
//   key_down       raw per-key pressed flags, bit i is key i
//   sample_en      one-cycle strobe requesting a new scan
//   tx_data        byte offered to the UART transmitter (FIFO head)
//   tx_valid       tx_data holds a valid byte (FIFO non-empty)
//   tx_ready       transmitter accepts the byte this cycle
//   key_state      debounced committed state per key
//   overflow       sticky: an event was refused because the FIFO was full
//   missed_sample  sticky: a sample strobe arrived while a scan was running
//
// Build option
//   KEY_EVENT_TIMESTAMP_EN  when defined, every event is followed by a second
//                           byte holding an 8-bit sample counter value taken
//                           at the start of the scan that produced it; both
//                           bytes are queued together or not at all.

module key_event_tx #(
    parameter int NUM_KEYS       = 40,
    parameter int STABLE_SAMPLES = 4,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_down,
    input  logic                sample_en,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                overflow,
    output logic                missed_sample
);

    localparam int IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CNT_W  = $clog2(STABLE_SAMPLES + 1);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
`ifdef KEY_EVENT_TIMESTAMP_EN
    localparam int EVENT_BYTES = 2;
`else
    localparam int EVENT_BYTES = 1;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_SAMPLES);
    localparam logic [PTR_W:0]   DEPTH_EXT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   NEED_EXT  = (PTR_W + 1)'(EVENT_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_KEYS-1:0] sample_reg;
    logic [IDX_W-1:0]    key_idx;
    logic [CNT_W-1:0]    counter [NUM_KEYS];

    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    logic                sample_accept;
    logic                sample_missed;
    logic                visit;

    logic                visit_bit;
    logic                committed_bit;
    logic                differs;
    logic [CNT_W-1:0]    cnt_cur;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    cnt_next;
    logic                hit_limit;
    logic                push;
    logic                refuse;
    logic                pop;
    logic [PTR_W-1:0]    fifo_count;
    logic [PTR_W:0]      fifo_space;
    logic [7:0]          event_byte;

`ifdef KEY_EVENT_TIMESTAMP_EN
    logic [7:0]          ts_count;
    logic [7:0]          ts_latched;
`endif

    // State register for the scan controller. Reset always returns to IDLE,
    // which also abandons any scan in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A strobe in IDLE starts a scan; the scan ends after
    // the cycle that visits the last key. Strobes that land mid-scan are
    // flagged but otherwise have no effect on the running scan.
    always_comb begin
        state_next    = state;
        sample_accept = 1'b0;
        sample_missed = 1'b0;
        visit         = 1'b0;
        case (state)
            IDLE: begin
                if (sample_en) begin
                    sample_accept = 1'b1;
                    state_next    = SCAN;
                end
            end
            SCAN: begin
                visit         = 1'b1;
                sample_missed = sample_en;
                if (key_idx == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-visit debounce decision. The counter saturates at its limit so a
    // change that could not be queued (FIFO full) is retried on the next
    // visit that still sees a differing sample. Free space includes a pop
    // happening in the same cycle, so a full FIFO can still take a push
    // while the transmitter drains it.
    always_comb begin
        visit_bit     = sample_reg[key_idx];
        committed_bit = key_state[key_idx];
        cnt_cur       = counter[key_idx];
        differs       = visit_bit ^ committed_bit;
        cnt_inc       = (cnt_cur >= CNT_MAX) ? CNT_MAX : cnt_cur + CNT_W'(1);

        pop           = tx_valid && tx_ready;
        fifo_count    = wr_ptr - rd_ptr;
        fifo_space    = DEPTH_EXT - {1'b0, fifo_count} + {{PTR_W{1'b0}}, pop};

        hit_limit     = visit && differs && (cnt_inc == CNT_MAX);
        push          = hit_limit && (fifo_space >= NEED_EXT);
        refuse        = hit_limit && !push;

        if (!differs) begin
            cnt_next = '0;
        end else if (push) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_inc;
        end

        event_byte    = {visit_bit, 7'(key_idx)};
    end

    // Scan datapath: snapshot the keys when a scan starts, then walk the key
    // index, update the visited key's counter, and flip its committed state
    // only when its event was actually queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_reg <= '0;
            key_idx    <= '0;
            key_state  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                counter[i] <= '0;
            end
        end else begin
            if (sample_accept) begin
                sample_reg <= key_down;
                key_idx    <= '0;
            end else if (visit) begin
                key_idx          <= (key_idx == LAST_IDX) ? '0 : key_idx + IDX_W'(1);
                counter[key_idx] <= cnt_next;
                if (push) begin
                    key_state[key_idx] <= visit_bit;
                end
            end
        end
    end

`ifdef KEY_EVENT_TIMESTAMP_EN
    // Sample counter for timestamps. The value in effect when a scan is
    // accepted is latched for that whole scan, then the counter advances
    // and wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_count   <= '0;
            ts_latched <= '0;
        end else if (sample_accept) begin
            ts_latched <= ts_count;
            ts_count   <= ts_count + 8'd1;
        end
    end
`endif

    // FIFO storage. The array itself is not reset: the pointers decide what
    // is valid, and the output is forced to zero while the FIFO is empty.
    // With timestamps enabled both bytes of an event are written together.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[ADDR_W-1:0]] <= event_byte;
`ifdef KEY_EVENT_TIMESTAMP_EN
            fifo_mem[(wr_ptr + PTR_W'(1)) & PTR_W'(FIFO_DEPTH - 1)] <= ts_latched;
`endif
        end
    end

    // FIFO pointers carry one extra wrap bit so full and empty can be told
    // apart; they count modulo twice the depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(EVENT_BYTES);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Transmit side: the head of the FIFO is offered directly, so it stays
    // put until the transmitter takes it.
    always_comb begin
        tx_valid = (wr_ptr != rd_ptr);
        tx_data  = tx_valid ? fifo_mem[rd_ptr[ADDR_W-1:0]] : 8'h00;
    end

    // Sticky status flags; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow      <= 1'b0;
            missed_sample <= 1'b0;
        end else begin
            if (refuse) begin
                overflow <= 1'b1;
            end
            if (sample_missed) begin
                missed_sample <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_event_tx.sv
// tb_key_event_tx
//
// Directed bench for key_event_tx. Instance A uses the default parameters,
// instance B uses a 4-byte FIFO for the overflow scenario. Bytes leaving
// each instance are collected into a queue and compared with hand-computed
// values. Setting KEY_EVENT_TIMESTAMP_EN swaps the overflow scenario on
// instance B for the timestamp scenario.

module tb_key_event_tx;

    localparam int NK = 40;
`ifdef KEY_EVENT_TIMESTAMP_EN
    localparam int EB = 2;
`else
    localparam int EB = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_down_a, key_down_b;
    logic          sample_en_a, sample_en_b;
    logic          tx_ready_a, tx_ready_b;
    logic [7:0]    tx_data_a, tx_data_b;
    logic          tx_valid_a, tx_valid_b;
    logic [NK-1:0] key_state_a, key_state_b;
    logic          overflow_a, overflow_b;
    logic          missed_a, missed_b;

    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [7:0]    q_a[$];
    logic [7:0]    q_b[$];

    always #5 clk = ~clk;

    key_event_tx #(.NUM_KEYS(NK), .STABLE_SAMPLES(4), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .key_down(key_down_a), .sample_en(sample_en_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .key_state(key_state_a), .overflow(overflow_a), .missed_sample(missed_a)
    );

    key_event_tx #(.NUM_KEYS(NK), .STABLE_SAMPLES(4), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .key_down(key_down_b), .sample_en(sample_en_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .key_state(key_state_b), .overflow(overflow_b), .missed_sample(missed_b)
    );

    // Collect transferred bytes mid-cycle, when the handshake is settled.
    always @(negedge clk) begin
        if (tx_valid_a && tx_ready_a) q_a.push_back(tx_data_a);
        if (tx_valid_b && tx_ready_b) q_b.push_back(tx_data_b);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] qByte(input bit sel, input int k);
        if (sel) return (k < q_b.size()) ? {56'd0, q_b[k]} : 64'hDEAD;
        else     return (k < q_a.size()) ? {56'd0, q_a[k]} : 64'hDEAD;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle sample strobe on the selected instance, then idle so that
    // `cycles` clock edges pass in total.
    task automatic applyStimulus(input bit sel, input int cycles);
        if (sel) sample_en_b = 1'b1; else sample_en_a = 1'b1;
        tick();
        sample_en_a = 1'b0;
        sample_en_b = 1'b0;
        repeat (cycles - 1) tick();
    endtask

    initial begin
        rst         = 1'b1;
        key_down_a  = '0;
        key_down_b  = '0;
        sample_en_a = 1'b0;
        sample_en_b = 1'b0;
        tx_ready_a  = 1'b0;
        tx_ready_b  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        checkOutput("reset_tx_valid", 64'(tx_valid_a), 64'd0);
        checkOutput("reset_tx_data", 64'(tx_data_a), 64'd0);
        checkOutput("reset_key_state", 64'(key_state_a), 64'd0);
        checkOutput("reset_overflow", 64'(overflow_a), 64'd0);
        checkOutput("reset_missed", 64'(missed_a), 64'd0);

        // Key 5 held down: committed on the fourth scan, single press byte.
        key_down_a = 40'h20;
        tx_ready_a = 1'b1;
        repeat (3) applyStimulus(1'b0, 100);
        checkOutput("press_none_after3", 64'(q_a.size()), 64'd0);
        checkOutput("press_state_after3", 64'(key_state_a[5]), 64'd0);
        sample_en_a = 1'b1;
        tick();
        sample_en_a = 1'b0;
        repeat (5) tick();
        checkOutput("press_latency_early", 64'(tx_valid_a), 64'd0);
        tick();
        checkOutput("press_latency_valid", 64'(tx_valid_a), 64'd1);
        checkOutput("press_latency_data", 64'(tx_data_a), 64'h85);
        repeat (93) tick();
        checkOutput("press_byte", qByte(1'b0, 0), 64'h85);
        checkOutput("press_state", 64'(key_state_a), 64'h20);
`ifdef KEY_EVENT_TIMESTAMP_EN
        checkOutput("press_ts", qByte(1'b0, 1), 64'h03);
`endif
        applyStimulus(1'b0, 100);
        checkOutput("press_one_event", 64'(q_a.size()), 64'(EB));

        // Key 39 pressed; on its committing scan a second strobe lands
        // three cycles in and must not disturb the scan.
        key_down_a = 40'h80_0000_0020;
        repeat (3) applyStimulus(1'b0, 100);
        checkOutput("missed_clear_before", 64'(missed_a), 64'd0);
        sample_en_a = 1'b1;
        tick();
        sample_en_a = 1'b0;
        tick();
        tick();
        sample_en_a = 1'b1;
        tick();
        sample_en_a = 1'b0;
        checkOutput("missed_set", 64'(missed_a), 64'd1);
        repeat (36) tick();
        checkOutput("last_key_early", 64'(tx_valid_a), 64'd0);
        tick();
        checkOutput("last_key_valid", 64'(tx_valid_a), 64'd1);
        checkOutput("last_key_data", 64'(tx_data_a), 64'hA7);
        repeat (59) tick();
        checkOutput("last_key_count", 64'(q_a.size()), 64'(2 * EB));
        checkOutput("last_key_byte", qByte(1'b0, EB), 64'hA7);
        checkOutput("last_key_state", 64'(key_state_a), 64'h80_0000_0020);

        // Release both keys with the transmitter stalled, then reset at the
        // visit of key 20 while the key 5 release byte is pending.
        tx_ready_a = 1'b0;
        key_down_a = '0;
        repeat (3) applyStimulus(1'b0, 100);
        checkOutput("release_pending_none", 64'(tx_valid_a), 64'd0);
        sample_en_a = 1'b1;
        tick();
        sample_en_a = 1'b0;
        repeat (20) tick();
        checkOutput("release_pending_valid", 64'(tx_valid_a), 64'd1);
        checkOutput("release_pending_data", 64'(tx_data_a), 64'h05);
        rst = 1'b1;
        tick();
        checkOutput("midscan_rst_valid", 64'(tx_valid_a), 64'd0);
        checkOutput("midscan_rst_data", 64'(tx_data_a), 64'd0);
        checkOutput("midscan_rst_state", 64'(key_state_a), 64'd0);
        checkOutput("midscan_rst_missed", 64'(missed_a), 64'd0);
        rst = 1'b0;
        tx_ready_a = 1'b1;
        repeat (100) tick();
        checkOutput("midscan_rst_no_bytes", 64'(q_a.size()), 64'(2 * EB));

        // Bouncing key: alternating samples never reach the limit.
        for (int i = 0; i < 6; i++) begin
            key_down_a = (i % 2 == 0) ? 40'h20 : 40'h0;
            applyStimulus(1'b0, 100);
        end
        checkOutput("bounce_no_bytes", 64'(q_a.size()), 64'(2 * EB));
        checkOutput("bounce_state", 64'(key_state_a), 64'd0);

`ifndef KEY_EVENT_TIMESTAMP_EN
        // Six keys pressed into a 4-byte FIFO with the transmitter stalled.
        key_down_b = 40'h3F;
        tx_ready_b = 1'b0;
        repeat (4) applyStimulus(1'b1, 100);
        checkOutput("ovf_flag", 64'(overflow_b), 64'd1);
        checkOutput("ovf_valid", 64'(tx_valid_b), 64'd1);
        checkOutput("ovf_head", 64'(tx_data_b), 64'h80);
        checkOutput("ovf_state", 64'(key_state_b), 64'h0F);
        repeat (10) tick();
        checkOutput("ovf_head_held", 64'(tx_data_b), 64'h80);
        tx_ready_b = 1'b1;
        repeat (10) tick();
        checkOutput("ovf_drain_count", 64'(q_b.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("ovf_drain_byte%0d", k), qByte(1'b1, k), 64'(8'h80 + k));
        end
        checkOutput("ovf_drain_empty", 64'(tx_valid_b), 64'd0);
        applyStimulus(1'b1, 100);
        checkOutput("ovf_retry_count", 64'(q_b.size()), 64'd6);
        checkOutput("ovf_retry_byte4", qByte(1'b1, 4), 64'h84);
        checkOutput("ovf_retry_byte5", qByte(1'b1, 5), 64'h85);
        checkOutput("ovf_retry_state", 64'(key_state_b), 64'h3F);
        checkOutput("ovf_sticky", 64'(overflow_b), 64'd1);
`else
        // Key 2 pressed for the first four accepted samples after reset.
        key_down_b = 40'h4;
        tx_ready_b = 1'b1;
        repeat (4) applyStimulus(1'b1, 100);
        checkOutput("ts_count", 64'(q_b.size()), 64'd2);
        checkOutput("ts_event", qByte(1'b1, 0), 64'h82);
        checkOutput("ts_stamp", qByte(1'b1, 1), 64'h03);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/key_event_tx.md
KEY_EVENT_TX -- requirements
Module: key_event_tx

Interface
REQ-001 Parameter NUM_KEYS, default 40, number of key inputs; legal range 1..128.
REQ-002 Parameter STABLE_SAMPLES, default 4, consecutive differing samples needed to commit a key change; minimum 1.
REQ-003 Parameter FIFO_DEPTH, default 16, event FIFO depth; power of two, minimum 2.
REQ-004 clk  input  1  the only clock in the block; all logic is rising-edge.
REQ-005 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-006 key_down  input  NUM_KEYS  raw per-key pressed flags; bit i is key i.
REQ-007 sample_en  input  1  one-cycle strobe; sample key_down now.
REQ-008 tx_data  output  8  byte offered to the UART transmitter.
REQ-009 tx_valid  output  1  tx_data holds a valid byte.
REQ-010 tx_ready  input  1  transmitter accepts; a byte transfers on a cycle with tx_valid and tx_ready both high.
REQ-011 key_state  output  NUM_KEYS  debounced committed state per key.
REQ-012 overflow  output  1  sticky; an event push was refused because the FIFO was full.
REQ-013 missed_sample  output  1  sticky; a sample_en arrived during SCAN.

Function
REQ-014 FSM states: IDLE and SCAN.
REQ-015 IDLE + sample_en: latch key_down into the sample register, set the key index to 0, go to SCAN.
REQ-016 SCAN visits one key per cycle, index 0 to NUM_KEYS-1, and returns to IDLE after the cycle that visits key NUM_KEYS-1.
REQ-017 sample_en during SCAN is ignored and sets missed_sample; the scan in progress is unaffected.
REQ-018 Visit, sample bit equals committed bit: clear that key's counter.
REQ-019 Visit, sample bit differs: increment the counter, saturating at STABLE_SAMPLES. If the counter reaches STABLE_SAMPLES and a push is possible: invert the committed bit, clear the counter, push one event.
REQ-020 Event byte = {new_state, key_index[6:0]}; new_state is 1 for press, 0 for release.
REQ-021 Push refused because the FIFO is full: set overflow; the committed bit does not change; the counter holds STABLE_SAMPLES, so the event is retried on the key's next visit with a differing sample.
REQ-022 A push is possible when the FIFO is full if a pop happens in the same cycle.
REQ-023 Latency: sample_en at cycle t gives a visit of key i at t+1+i; a pushed byte is visible on tx_data/tx_valid at t+2+i at the earliest.
REQ-024 tx_valid equals FIFO non-empty; tx_data is the FIFO head; tx_data is held stable while tx_valid is high and tx_ready is low.
REQ-025 Events leave in push order (ascending key index within a scan, then scan order).
REQ-026 Per-key counter width is clog2(STABLE_SAMPLES+1); FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.

Reset
REQ-027 rst forces: FSM to IDLE, key index 0, all counters 0, key_state all 0, FIFO empty, tx_valid 0, tx_data 0, overflow 0, missed_sample 0, timestamp 0.
REQ-028 rst during SCAN aborts the scan; the partial scan leaves no state behind and no event is emitted.
REQ-029 Sticky flags clear only on rst.

Configuration
REQ-030 Macro KEY_EVENT_TIMESTAMP_EN.
- Defined: an 8-bit sample counter increments on every accepted sample_en and wraps 255 to 0.
- Defined: each event is two bytes, the event byte and then the counter value latched at the start of the scan.
- Defined: an event is pushed only if both bytes fit in the FIFO; a half event never appears.
- Not defined: events are single bytes and the counter logic is absent.

Verification
REQ-031 Defaults. key_down bit 5 = 1, five sample_en strobes 100 cycles apart, tx_ready = 1. The fourth scan produces byte 0x85; key_state[5] = 1; exactly one byte is emitted.
REQ-032 Bit 5 toggles 1,0,1,0,1,0 across six samples. No event is emitted and key_state[5] stays 0.
REQ-033 FIFO_DEPTH = 4, tx_ready = 0. Bits 0..5 set and held for four samples. Bytes 0x80..0x83 are queued and overflow = 1. After tx_ready = 1 and one more sample, 0x84 and 0x85 follow.
REQ-034 A second sample_en 3 cycles after the first. missed_sample = 1, and the scan completes NUM_KEYS cycles after the first strobe.
REQ-035 rst asserted at the visit of key 20 while events are pending. The next cycle shows tx_valid = 0 and key_state = 0, and no byte appears afterwards.
REQ-036 KEY_EVENT_TIMESTAMP_EN defined, key 2 pressed at accepted samples 1..4. Bytes 0x82 then 0x03 are emitted.
